max31855_ascii_formatter: RTL

Sits between the MAX31855 SPI master and the UART transmitter, in the slot where the loopback checker now sits. Detects the end of each 32-bit thermocouple read (rising edge of the SPI chip-select), captures the frame, and decodes the 14-bit thermocouple temperature or the fault flags. Converts the value to fixed-format ASCII and streams it byte by byte through the UART tx_start/tx_done_tick handshake.

---
 rtl/max31855_ascii_formatter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/max31855_ascii_formatter.sv
// Captures a MAX31855 frame on the rising edge of chip-select and streams it
// to a byte UART as fixed-width ASCII ("+0025.00C\r\n" or "FLT:OGV\r\n").
module max31855_ascii_formatter #(
  parameter bit FRAC_EN  = 1'b1,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic [31:0] frame_in,
  input  logic        tx_ready,
  input  logic        tx_done_tick,
  output logic        tx_start,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic        frame_drop
);

  localparam int EOL_LEN = EOL_CRLF ? 2 : 1;
  localparam logic [3:0] TEMP_LAST  = 4'(5 + (FRAC_EN ? 3 : 0) + EOL_LEN);
  localparam logic [3:0] FAULT_LAST = 4'(6 + EOL_LEN);

  typedef enum logic [2:0] {ST_IDLE, ST_CONV, ST_LOAD, ST_SEND, ST_WAIT} state_t;

  state_t      state_reg, state_next;
  logic        cs_meta_reg, cs_sync_reg, cs_prev_reg;
  logic        cs_rise;
  logic [13:0] temp_reg, temp_next;
  logic        fault_reg, fault_next;
  logic [2:0]  flags_reg, flags_next;
  logic [15:0] bcd_reg, bcd_next;
  logic [3:0]  conv_cnt_reg, conv_cnt_next;
  logic [3:0]  char_idx_reg, char_idx_next;
  logic        tx_start_reg, tx_start_next;
  logic [7:0]  w_data_reg, w_data_next;
  logic        busy_reg, busy_next;
  logic        drop_reg, drop_next;

  logic signed [14:0] temp_ext;
  logic [14:0] mag;
  logic [12:0] int_val;
  logic [1:0]  frac;
  logic [15:0] bcd_adj;
  logic [3:0]  last_idx;
  logic [7:0]  char_sel;
  logic        unused_bits;

  assign cs_rise = cs_sync_reg & ~cs_prev_reg;

  // 15-bit magnitude so that -8192 (-2048.00 C) stays representable.
  assign temp_ext = {temp_reg[13], temp_reg};
  assign mag      = temp_reg[13] ? $unsigned(-temp_ext) : $unsigned(temp_ext);
  assign int_val  = mag[14:2];
  assign frac     = mag[1:0];
  assign last_idx = fault_reg ? FAULT_LAST : TEMP_LAST;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
  end

  assign unused_bits = ^{frame_in[17], frame_in[15:3], bcd_adj[15]};

  always_comb begin
    char_sel = (EOL_CRLF && char_idx_reg != last_idx) ? 8'h0D : 8'h0A;
    if (fault_reg) begin
      case (char_idx_reg)
        4'd0: char_sel = "F";
        4'd1: char_sel = "L";
        4'd2: char_sel = "T";
        4'd3: char_sel = ":";
        4'd4: char_sel = flags_reg[0] ? "O" : "-";
        4'd5: char_sel = flags_reg[1] ? "G" : "-";
        4'd6: char_sel = flags_reg[2] ? "V" : "-";
        default: ;
      endcase
    end else begin
      case (char_idx_reg)
        4'd0: char_sel = temp_reg[13] ? "-" : "+";
        4'd1: char_sel = {4'h3, bcd_reg[15:12]};
        4'd2: char_sel = {4'h3, bcd_reg[11:8]};
        4'd3: char_sel = {4'h3, bcd_reg[7:4]};
        4'd4: char_sel = {4'h3, bcd_reg[3:0]};
        4'd5: char_sel = FRAC_EN ? "." : "C";
        4'd6: if (FRAC_EN) begin
          case (frac)
            2'd0:    char_sel = "0";
            2'd1:    char_sel = "2";
            2'd2:    char_sel = "5";
            default: char_sel = "7";
          endcase
        end
        4'd7: if (FRAC_EN) char_sel = frac[0] ? "5" : "0";
        4'd8: if (FRAC_EN) char_sel = "C";
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state_reg;
    temp_next     = temp_reg;
    fault_next    = fault_reg;
    flags_next    = flags_reg;
    bcd_next      = bcd_reg;
    conv_cnt_next = conv_cnt_reg;
    char_idx_next = char_idx_reg;
    tx_start_next = 1'b0;
    w_data_next   = w_data_reg;
    busy_next     = busy_reg;
    drop_next     = drop_reg | (cs_rise & (state_reg != ST_IDLE));
    case (state_reg)
      ST_IDLE: if (cs_rise) begin
        temp_next     = frame_in[31:18];
        fault_next    = frame_in[16];
        flags_next    = frame_in[2:0];
        bcd_next      = 16'd0;
        conv_cnt_next = 4'd0;
        char_idx_next = 4'd0;
        busy_next     = 1'b1;
        state_next    = frame_in[16] ? ST_LOAD : ST_CONV;
      end
      // One double-dabble step per clock, integer MSB first.
      ST_CONV: begin
        bcd_next      = {bcd_adj[14:0], int_val[4'd12 - conv_cnt_reg]};
        conv_cnt_next = conv_cnt_reg + 4'd1;
        if (conv_cnt_reg == 4'd12) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_data_next = char_sel;
        state_next  = ST_SEND;
      end
      ST_SEND: if (tx_ready) begin
        tx_start_next = 1'b1;
        state_next    = ST_WAIT;
      end
      ST_WAIT: if (tx_done_tick) begin
        if (char_idx_reg == last_idx) begin
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else begin
          char_idx_next = char_idx_reg + 4'd1;
          state_next    = ST_LOAD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cs_meta_reg  <= 1'b1;
      cs_sync_reg  <= 1'b1;
      cs_prev_reg  <= 1'b1;
      temp_reg     <= 14'd0;
      fault_reg    <= 1'b0;
      flags_reg    <= 3'd0;
      bcd_reg      <= 16'd0;
      conv_cnt_reg <= 4'd0;
      char_idx_reg <= 4'd0;
      tx_start_reg <= 1'b0;
      w_data_reg   <= 8'h00;
      busy_reg     <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cs_meta_reg  <= spi_cs;
      cs_sync_reg  <= cs_meta_reg;
      cs_prev_reg  <= cs_sync_reg;
      temp_reg     <= temp_next;
      fault_reg    <= fault_next;
      flags_reg    <= flags_next;
      bcd_reg      <= bcd_next;
      conv_cnt_reg <= conv_cnt_next;
      char_idx_reg <= char_idx_next;
      tx_start_reg <= tx_start_next;
      w_data_reg   <= w_data_next;
      busy_reg     <= busy_next;
      drop_reg     <= drop_next;
    end
  end

  assign tx_start   = tx_start_reg;
  assign w_data     = w_data_reg;
  assign busy       = busy_reg;
  assign frame_drop = drop_reg;

endmodule
